// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer of the 8-bit CPU.
//  - OPC_W / OP_* : instruction opcode width and opcode values (IR[7:4])
//  - state_e      : fetch/execute FSM states
//  - ctrl_t       : one datapath control word (all strobes of a single cycle)
//  - is_mem_op()  : opcodes that need a RAM access in their execute phase
package control_sequencer_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPC_W-1:0] OP_STA = 4'h4;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
  localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    StF0,
    StF1,
    StE0,
    StE1,
    StE2,
    StHalt
  } state_e;

  typedef struct packed {
    logic pc_inc;
    logic pc_load;
    logic pc_out;
    logic mar_load;
    logic ir_out;
    logic ram_oe;
    logic ram_we;
    logic ir_load;
    logic a_load;
    logic b_load;
    logic a_out;
    logic alu_out;
    logic alu_sub;
    logic flags_load;
    logic out_load;
    logic instr_done;
    logic halted;
  } ctrl_t;

  function automatic logic is_mem_op(logic [OPC_W-1:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the CPU datapath.
//  master : the sequencer (takes opcode/flags/mem_ready/step, drives strobes)
//  slave  : the datapath side (drives opcode/flags/mem_ready/step, takes strobes)
interface control_sequencer_if;
  import control_sequencer_pkg::*;

  logic [OPC_W-1:0] ir_opcode;
  logic             carry_flag;
  logic             zero_flag;
  logic             mem_ready;
  logic             step;

  logic pc_inc, pc_load, pc_out, mar_load, ir_out, ram_oe, ram_we;
  logic ir_load, a_load, b_load, a_out, alu_out, alu_sub, flags_load;
  logic out_load, instr_done, halted;

  modport master (
    input  ir_opcode, carry_flag, zero_flag, mem_ready, step,
    output pc_inc, pc_load, pc_out, mar_load, ir_out, ram_oe, ram_we,
    output ir_load, a_load, b_load, a_out, alu_out, alu_sub, flags_load,
    output out_load, instr_done, halted
  );

  modport slave (
    output ir_opcode, carry_flag, zero_flag, mem_ready, step,
    input  pc_inc, pc_load, pc_out, mar_load, ir_out, ram_oe, ram_we,
    input  ir_load, a_load, b_load, a_out, alu_out, alu_sub, flags_load,
    input  out_load, instr_done, halted
  );

endinterface

// File: rtl/control_sequencer_step_sync.sv
// Single-step request conditioning: 2-FF synchroniser followed by a rising-edge
// detector. Only instantiated when SINGLE_STEP_EN is defined.
//  clk_i  : clock
//  rst_ni : asynchronous active-low reset
//  step_i : asynchronous step level
//  rise_o : one-cycle pulse after a synchronised 0->1 transition
module step_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic step_i,
  output logic rise_o
);

  // [0],[1] synchroniser stages, [2] previous synchronised value
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], step_i};
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/execute sequencer for the 8-bit CPU. One micro-step per
// clock; memory steps stretch until mem_ready. Strobes are decoded from the
// registered state (plus opcode/flags/mem_ready) and forced to 0 during reset.
//  clk     : system clock, rising edge
//  reset_n : asynchronous active-low reset
//  bus     : control_sequencer_if.master (opcode, flags, mem_ready, step in;
//            all datapath strobes, instr_done and halted out)
// Build option: define SINGLE_STEP_EN to gate each instruction on a rising
// edge of bus.step; otherwise step is ignored and the FSM free-runs.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input logic                 clk,
  input logic                 reset_n,
  control_sequencer_if.master bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl, ctrl_out;
  logic   go;

`ifdef SINGLE_STEP_EN
  logic step_rise;
  logic armed_q, armed_d;

  step_sync u_step_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .step_i (bus.step),
    .rise_o (step_rise)
  );

  // Armed by a step edge seen while idling in fetch, disarmed when the
  // instruction completes.
  always_comb begin
    armed_d = armed_q;
    if (state_q == StF0 && step_rise) armed_d = 1'b1;
    if (ctrl.instr_done) armed_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) armed_q <= 1'b0;
    else          armed_q <= armed_d;
  end

  assign go = armed_q;
`else
  logic unused_step;
  assign unused_step = bus.step;
  assign go          = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StF0;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    unique case (state_q)
      StF0: begin
        if (go) begin
          ctrl.pc_out   = 1'b1;
          ctrl.mar_load = 1'b1;
          state_d       = StF1;
        end
      end
      StF1: begin
        ctrl.ram_oe = 1'b1;
        if (bus.mem_ready) begin
          ctrl.ir_load = 1'b1;
          ctrl.pc_inc  = 1'b1;
          state_d      = StE0;
        end
      end
      StE0: begin
        ctrl.instr_done = 1'b1;
        state_d         = StF0;
        if (is_mem_op(bus.ir_opcode)) begin
          ctrl.ir_out     = 1'b1;
          ctrl.mar_load   = 1'b1;
          ctrl.instr_done = 1'b0;
          state_d         = StE1;
        end else begin
          case (bus.ir_opcode)
            OP_LDI: begin
              ctrl.ir_out = 1'b1;
              ctrl.a_load = 1'b1;
            end
            OP_JMP: begin
              ctrl.ir_out  = 1'b1;
              ctrl.pc_load = 1'b1;
            end
            OP_JC: begin
              ctrl.ir_out  = bus.carry_flag;
              ctrl.pc_load = bus.carry_flag;
            end
            OP_JZ: begin
              ctrl.ir_out  = bus.zero_flag;
              ctrl.pc_load = bus.zero_flag;
            end
            OP_OUT: begin
              ctrl.a_out    = 1'b1;
              ctrl.out_load = 1'b1;
            end
            OP_HLT: begin
              ctrl.instr_done = 1'b0;
              state_d         = StHalt;
            end
            default: ;  // NOP and unused opcodes
          endcase
        end
      end
      StE1: begin
        state_d = StF0;
        case (bus.ir_opcode)
          OP_LDA: begin
            ctrl.ram_oe = 1'b1;
            if (!bus.mem_ready) state_d = StE1;
            else begin
              ctrl.a_load     = 1'b1;
              ctrl.instr_done = 1'b1;
            end
          end
          OP_ADD, OP_SUB: begin
            ctrl.ram_oe = 1'b1;
            if (!bus.mem_ready) state_d = StE1;
            else begin
              ctrl.b_load = 1'b1;
              state_d     = StE2;
            end
          end
          OP_STA: begin
            ctrl.a_out  = 1'b1;
            ctrl.ram_we = 1'b1;
            if (!bus.mem_ready) state_d = StE1;
            else ctrl.instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      StE2: begin
        ctrl.alu_out    = 1'b1;
        ctrl.a_load     = 1'b1;
        ctrl.flags_load = 1'b1;
        ctrl.alu_sub    = (bus.ir_opcode == OP_SUB);
        ctrl.instr_done = 1'b1;
        state_d         = StF0;
      end
      StHalt: begin
        ctrl.halted = 1'b1;
      end
      default: state_d = StF0;
    endcase
  end

  // Reset forces outputs low immediately, not just from the next edge.
  assign ctrl_out = reset_n ? ctrl : '0;

  assign bus.pc_inc     = ctrl_out.pc_inc;
  assign bus.pc_load    = ctrl_out.pc_load;
  assign bus.pc_out     = ctrl_out.pc_out;
  assign bus.mar_load   = ctrl_out.mar_load;
  assign bus.ir_out     = ctrl_out.ir_out;
  assign bus.ram_oe     = ctrl_out.ram_oe;
  assign bus.ram_we     = ctrl_out.ram_we;
  assign bus.ir_load    = ctrl_out.ir_load;
  assign bus.a_load     = ctrl_out.a_load;
  assign bus.b_load     = ctrl_out.b_load;
  assign bus.a_out      = ctrl_out.a_out;
  assign bus.alu_out    = ctrl_out.alu_out;
  assign bus.alu_sub    = ctrl_out.alu_sub;
  assign bus.flags_load = ctrl_out.flags_load;
  assign bus.out_load   = ctrl_out.out_load;
  assign bus.instr_done = ctrl_out.instr_done;
  assign bus.halted     = ctrl_out.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised bench for control_sequencer. The driver expands each instruction
// into its per-cycle strobe sequence from the instruction table and pushes the
// expected control word per cycle; a monitor pops and compares every cycle.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  localparam logic [16:0] M_PC_INC   = 17'h00001;
  localparam logic [16:0] M_PC_LOAD  = 17'h00002;
  localparam logic [16:0] M_PC_OUT   = 17'h00004;
  localparam logic [16:0] M_MAR_LOAD = 17'h00008;
  localparam logic [16:0] M_IR_OUT   = 17'h00010;
  localparam logic [16:0] M_RAM_OE   = 17'h00020;
  localparam logic [16:0] M_RAM_WE   = 17'h00040;
  localparam logic [16:0] M_IR_LOAD  = 17'h00080;
  localparam logic [16:0] M_A_LOAD   = 17'h00100;
  localparam logic [16:0] M_B_LOAD   = 17'h00200;
  localparam logic [16:0] M_A_OUT    = 17'h00400;
  localparam logic [16:0] M_ALU_OUT  = 17'h00800;
  localparam logic [16:0] M_ALU_SUB  = 17'h01000;
  localparam logic [16:0] M_FLAGS    = 17'h02000;
  localparam logic [16:0] M_OUT_LOAD = 17'h04000;
  localparam logic [16:0] M_DONE     = 17'h08000;
  localparam logic [16:0] M_HALTED   = 17'h10000;

  typedef struct {
    logic [16:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [16:0] act;

  assign act = {bus.halted, bus.instr_done, bus.out_load, bus.flags_load, bus.alu_sub,
                bus.alu_out, bus.a_out, bus.b_load, bus.a_load, bus.ir_load, bus.ram_we,
                bus.ram_oe, bus.ir_out, bus.mar_load, bus.pc_out, bus.pc_load, bus.pc_inc};

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  // Step level outside the single-step pulse: random when ignored, low otherwise.
  function automatic logic sidle();
`ifdef SINGLE_STEP_EN
    return 1'b0;
`else
    return rbit();
`endif
  endfunction

  // Drive one cycle of inputs and record the strobes expected during it.
  task automatic cycle(input logic rst, input logic [3:0] op, input logic cf, input logic zf,
                       input logic mr, input logic stp, input logic [16:0] e, input string nm);
    exp_t item;
    @(negedge clk);
    reset_n        = rst;
    bus.ir_opcode  = op;
    bus.carry_flag = cf;
    bus.zero_flag  = zf;
    bus.mem_ready  = mr;
    bus.step       = stp;
    item.exp       = e;
    item.name      = nm;
    sb_q.push_back(item);
  endtask

  // Memory step: 'hold' for we wait cycles, then hold|fin on the mem_ready cycle.
  // abort >= 0 puts reset in after that many wait cycles instead.
  task automatic mem_step(input logic [3:0] op, input logic cf, input logic zf, input int we,
                          input int abort, input logic [16:0] hold, input logic [16:0] fin,
                          input string nm);
    int n;
    n = (abort >= 0) ? abort : we;
    for (int i = 0; i < n; i++) cycle(1, op, cf, zf, 0, sidle(), hold, {nm, "-wait"});
    if (abort >= 0) begin
      cycle(0, op, cf, zf, 0, 1'b0, '0, {nm, "-rst_async"});
      cycle(0, op, cf, zf, 0, 1'b0, '0, {nm, "-rst_hold"});
    end else begin
      cycle(1, op, cf, zf, 1, sidle(), hold | fin, {nm, "-ready"});
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input logic cf, input logic zf, input int wf,
                           input int we, input int abort, input string nm);
    logic [16:0] e;
`ifdef SINGLE_STEP_EN
    repeat ($urandom_range(0, 3)) cycle(1, rop(), cf, zf, rbit(), 1'b0, '0, {nm, "-idle"});
    cycle(1, rop(), cf, zf, rbit(), 1'b1, '0, {nm, "-step"});
    repeat (2) cycle(1, rop(), cf, zf, rbit(), 1'b0, '0, {nm, "-sync"});
`endif
    cycle(1, rop(), cf, zf, rbit(), sidle(), M_PC_OUT | M_MAR_LOAD, {nm, "-F0"});
    for (int i = 0; i < wf; i++) cycle(1, rop(), cf, zf, 0, sidle(), M_RAM_OE, {nm, "-F1w"});
    cycle(1, rop(), cf, zf, 1, sidle(), M_RAM_OE | M_IR_LOAD | M_PC_INC, {nm, "-F1"});
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4: begin
        cycle(1, op, cf, zf, rbit(), sidle(), M_IR_OUT | M_MAR_LOAD, {nm, "-E0"});
        if (op == 4'h1) mem_step(op, cf, zf, we, abort, M_RAM_OE, M_A_LOAD | M_DONE, nm);
        else if (op == 4'h4) mem_step(op, cf, zf, we, abort, M_A_OUT | M_RAM_WE, M_DONE, nm);
        else begin
          mem_step(op, cf, zf, we, abort, M_RAM_OE, M_B_LOAD, nm);
          if (abort < 0) begin
            e = M_ALU_OUT | M_A_LOAD | M_FLAGS | M_DONE | ((op == 4'h3) ? M_ALU_SUB : '0);
            cycle(1, op, cf, zf, rbit(), sidle(), e, {nm, "-E2"});
          end
        end
      end
      4'hF: begin
        cycle(1, op, cf, zf, rbit(), sidle(), '0, {nm, "-E0"});
        for (int i = 0; i < 20; i++)
          cycle(1, rop(), rbit(), rbit(), rbit(), sidle(), M_HALTED, {nm, "-halt"});
        cycle(0, rop(), cf, zf, 0, 1'b0, '0, {nm, "-rst"});
      end
      default: begin
        case (op)
          4'h5:    e = M_IR_OUT | M_A_LOAD;
          4'h6:    e = M_IR_OUT | M_PC_LOAD;
          4'h7:    e = cf ? (M_IR_OUT | M_PC_LOAD) : '0;
          4'h8:    e = zf ? (M_IR_OUT | M_PC_LOAD) : '0;
          4'hE:    e = M_A_OUT | M_OUT_LOAD;
          default: e = '0;
        endcase
        cycle(1, op, cf, zf, rbit(), sidle(), e | M_DONE, {nm, "-E0"});
      end
    endcase
  endtask

  // Monitor: compares the strobes mid-cycle, after the driver has set inputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s at %0t: strobes got %05h want %05h", e.name, $time, act, e.exp);
        end
      end
    end
  end

  initial begin
    int guard;
    logic [3:0] op;
    bus.ir_opcode  = '0;
    bus.carry_flag = 1'b0;
    bus.zero_flag  = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.step       = 1'b0;

    cycle(0, 4'h0, 0, 0, 1, 1'b0, '0, "reset_a");
    cycle(0, 4'h1, 1, 1, 1, 1'b0, '0, "reset_b");

    run_instr(4'h5, 0, 0, 0, 0, -1, "ldi");
    run_instr(4'hE, 0, 0, 0, 0, -1, "out");
    run_instr(4'h2, 1, 0, 0, 3, -1, "add_wait3");
    run_instr(4'h3, 0, 1, 2, 1, -1, "sub_wait");
    run_instr(4'h7, 0, 1, 0, 0, -1, "jc_nc");
    run_instr(4'h7, 1, 0, 0, 0, -1, "jc_c");
    run_instr(4'h8, 1, 0, 0, 0, -1, "jz_nz");
    run_instr(4'h8, 0, 1, 0, 0, -1, "jz_z");
    run_instr(4'h4, 0, 0, 1, 2, -1, "sta_wait");
    run_instr(4'h1, 0, 0, 0, 0, 2, "lda_rst_e1");
    run_instr(4'hB, 0, 0, 0, 0, -1, "nop_b");
    run_instr(4'hF, 0, 0, 0, 0, -1, "hlt");
    run_instr(4'h6, 0, 0, 0, 0, -1, "jmp_after_hlt");

    for (int k = 0; k < 150; k++) begin
      op = rop();
      run_instr(op, rbit(), rbit(), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : 0,
                ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : 0,
                ($urandom_range(0, 15) == 0 && (op >= 4'h1 && op <= 4'h4))
                  ? $urandom_range(0, 2) : -1,
                $sformatf("rnd%0d_op%h", k, op));
    end

    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #5;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: pending %0d want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
